// File: rtl/ir_command_receiver_pkg.sv
// Shared definitions for the IR command link: FSM states, SIRC timing constants and
// command field layout. The transmitter side uses the same constants.
package ir_command_receiver_pkg;

  localparam bit IR_ACTIVE_LOW = 1'b1;

  // Timing in 25 MHz clock cycles.
  localparam int START_MIN     = 50000;
  localparam int START_MAX     = 70000;
  localparam int BIT_MIN       = 10000;
  localparam int BIT_THRESHOLD = 22500;
  localparam int BIT_MAX       = 37500;
  localparam int GAP_TIMEOUT   = 25000;

  localparam int CNT_W      = 20;
  localparam int CMD_W      = 12;
  localparam int FRAME_BITS = 12;
  localparam int ANGLE_MSB  = 11;
  localparam int ANGLE_LSB  = 7;
  localparam int DIST_MSB   = 6;

  typedef logic [CNT_W:0] width_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_SPACE = 3'd2,
    ST_BIT   = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } state_e;

endpackage

// File: rtl/ir_command_receiver_if.sv
// Command handshake between the IR receiver (master) and the motor signal stream (slave).
interface ir_command_receiver_if;
  import ir_command_receiver_pkg::*;

  logic             move_done;
  logic [CMD_W-1:0] command;
  logic             command_ready;
  logic             busy;

  modport master (input move_done, output command, command_ready, busy);
  modport slave  (output move_done, input command, command_ready, busy);

endinterface

// File: rtl/ir_command_receiver_sync.sv
// Brings the asynchronous IR detector output into the clock domain, converts it to
// "mark" polarity and produces single-cycle rise/fall pulses on the mark signal.
module ir_command_receiver_sync #(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic ir_i,
  output logic mark_o,
  output logic rise_o,
  output logic fall_o
);

  logic sync1_q, sync2_q, markPrev_q;

  // Flops reset to the idle (no carrier) level so leaving reset never looks like an edge.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      sync1_q    <= ACTIVE_LOW;
      sync2_q    <= ACTIVE_LOW;
      markPrev_q <= 1'b0;
    end else begin
      sync1_q    <= ir_i;
      sync2_q    <= sync1_q;
      markPrev_q <= mark_o;
    end
  end

  assign mark_o = sync2_q ^ ACTIVE_LOW;
  assign rise_o = mark_o & ~markPrev_q;
  assign fall_o = ~mark_o & markPrev_q;

endmodule

// File: rtl/ir_command_receiver.sv
// IR command receiver: decodes 12-bit SIRC-style frames (LSB first) into move commands
// and holds off new commands until the motor stage reports move_done.
module ir_command_receiver
  import ir_command_receiver_pkg::*;
#(
  parameter bit IR_ACTIVE_LOW_CFG = IR_ACTIVE_LOW,
  parameter int START_MIN_CYC     = START_MIN,
  parameter int START_MAX_CYC     = START_MAX,
  parameter int BIT_MIN_CYC       = BIT_MIN,
  parameter int BIT_THRESHOLD_CYC = BIT_THRESHOLD,
  parameter int BIT_MAX_CYC       = BIT_MAX,
  parameter int GAP_TIMEOUT_CYC   = GAP_TIMEOUT
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  ir_in_i,
  ir_command_receiver_if.master cmd_if,
  output logic                  frame_error_o,
  output logic [2:0]            state_o
);

  localparam width_t START_MIN_W = width_t'(START_MIN_CYC);
  localparam width_t START_MAX_W = width_t'(START_MAX_CYC);
  localparam width_t BIT_MIN_W   = width_t'(BIT_MIN_CYC);
  localparam width_t BIT_THR_W   = width_t'(BIT_THRESHOLD_CYC);
  localparam width_t BIT_MAX_W   = width_t'(BIT_MAX_CYC);
  localparam width_t GAP_W       = width_t'(GAP_TIMEOUT_CYC);

  logic             mark, markRise, markFall;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] widthCnt_q;
  width_t           width;
  logic [CMD_W-1:0] shift_q, shift_d, command_q, command_d;
  logic [3:0]       bitCnt_q, bitCnt_d;
  logic             ready_q, ready_d, busy_q, busy_d, frameError_q, frameError_d;

  ir_command_receiver_sync #(.ACTIVE_LOW(IR_ACTIVE_LOW_CFG)) u_sync (
    .clock_i(clock_i),
    .reset_i(reset_i),
    .ir_i   (ir_in_i),
    .mark_o (mark),
    .rise_o (markRise),
    .fall_o (markFall)
  );

  // On an edge cycle, width is exactly the length of the level that just ended.
  assign width = width_t'(widthCnt_q) + width_t'(1);

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      widthCnt_q <= '0;
    end else if (markRise || markFall) begin
      widthCnt_q <= '0;
    end else if (widthCnt_q != '1) begin
      widthCnt_q <= widthCnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      bitCnt_q     <= '0;
      command_q    <= '0;
      ready_q      <= 1'b0;
      busy_q       <= 1'b0;
      frameError_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bitCnt_q     <= bitCnt_d;
      command_q    <= command_d;
      ready_q      <= ready_d;
      busy_q       <= busy_d;
      frameError_q <= frameError_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bitCnt_d  = bitCnt_q;
    command_d = command_q;
    ready_d   = 1'b0;
    busy_d    = busy_q;
    if (cmd_if.move_done) busy_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (markRise) state_d = ST_START;
      end
      ST_START: begin
        if (markFall) begin
          if (width >= START_MIN_W && width <= START_MAX_W) begin
            state_d  = ST_SPACE;
            bitCnt_d = '0;
          end else begin
            state_d = ST_ERROR;
          end
        end else if (mark && width > START_MAX_W) begin
          state_d = ST_ERROR;
        end
      end
      ST_SPACE: begin
        if (markRise) state_d = ST_BIT;
        else if (width >= GAP_W) state_d = ST_ERROR;
      end
      ST_BIT: begin
        if (markFall) begin
          if (width < BIT_MIN_W || width > BIT_MAX_W) begin
            state_d = ST_ERROR;
          end else begin
            shift_d[bitCnt_q] = (width >= BIT_THR_W);
            bitCnt_d          = bitCnt_q + 4'd1;
            state_d           = (bitCnt_q == 4'(FRAME_BITS - 1)) ? ST_DONE : ST_SPACE;
          end
        end else if (mark && width > BIT_MAX_W) begin
          state_d = ST_ERROR;
        end
      end
      ST_DONE: begin
        // A move_done arriving in this very cycle frees the slot for the new command.
        if (!busy_q || cmd_if.move_done) begin
          command_d = {shift_q[ANGLE_MSB:ANGLE_LSB], shift_q[DIST_MSB:0]};
          ready_d   = 1'b1;
          busy_d    = 1'b1;
        end
        state_d = markRise ? ST_START : ST_IDLE;
      end
      ST_ERROR: begin
        if (!mark && !markFall && width >= GAP_W) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    frameError_d = (state_d == ST_ERROR) && (state_q != ST_ERROR);
  end

  assign cmd_if.command       = command_q;
  assign cmd_if.command_ready = ready_q;
  assign cmd_if.busy          = busy_q;
  assign frame_error_o        = frameError_q;
  assign state_o              = state_q;

endmodule

// File: tb/tb_ir_command_receiver.sv
// Self-checking bench for ir_command_receiver with scaled-down timing and a frame-level
// reference model (decoded value, frame validity, accept/drop against busy).
module tb_ir_command_receiver;
  import ir_command_receiver_pkg::*;

  localparam int S_START_MIN = 50;
  localparam int S_START_MAX = 70;
  localparam int S_BIT_MIN   = 10;
  localparam int S_THRESH    = 22;
  localparam int S_BIT_MAX   = 37;
  localparam int S_GAP       = 25;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       irIn  = 1'b1;
  logic       frameError;
  logic [2:0] stateOut;

  ir_command_receiver_if cmdIf();

  ir_command_receiver #(
    .IR_ACTIVE_LOW_CFG(1'b1),
    .START_MIN_CYC(S_START_MIN),
    .START_MAX_CYC(S_START_MAX),
    .BIT_MIN_CYC(S_BIT_MIN),
    .BIT_THRESHOLD_CYC(S_THRESH),
    .BIT_MAX_CYC(S_BIT_MAX),
    .GAP_TIMEOUT_CYC(S_GAP)
  ) dut (
    .clock_i      (clock),
    .reset_i      (reset),
    .ir_in_i      (irIn),
    .cmd_if       (cmdIf),
    .frame_error_o(frameError),
    .state_o      (stateOut)
  );

  always #5 clock = ~clock;

  int          errors = 0;
  int          checks = 0;
  int          readyCount = 0;
  int          errCount = 0;
  logic [11:0] readyCmd = '0;
  int          expReady = 0;
  int          expErr = 0;
  logic [11:0] mCmd = '0;
  logic        mBusy = 1'b0;
  int          bitW[12];
  int          spaceW[12];

  // Pulse monitor: counts command_ready and frame_error pulses, latches command on ready.
  always @(negedge clock) begin
    if (cmdIf.command_ready === 1'b1) begin
      readyCount++;
      readyCmd = cmdIf.command;
    end
    if (frameError === 1'b1) errCount++;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic hold(input logic lvl, input int n);
    irIn = lvl;
    repeat (n) @(negedge clock);
  endtask

  task automatic fill_fixed(input logic [11:0] val);
    for (int i = 0; i < 12; i++) begin
      bitW[i]   = val[i] ? 30 : 15;
      spaceW[i] = 15;
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 12; i++) begin
      bitW[i]   = int'($urandom_range(S_BIT_MIN, S_BIT_MAX));
      spaceW[i] = int'($urandom_range(3, S_GAP - 1));
    end
  endtask

  // Start mark then nBits (space, mark) pairs; ends with the last mark still asserted.
  task automatic send_raw(input int startW, input int nBits);
    hold(1'b0, startW);
    for (int i = 0; i < nBits; i++) begin
      hold(1'b1, spaceW[i]);
      hold(1'b0, bitW[i]);
    end
  endtask

  function automatic logic [11:0] model_value();
    logic [11:0] v = '0;
    for (int i = 0; i < 12; i++) if (bitW[i] >= S_THRESH) v[i] = 1'b1;
    return v;
  endfunction

  function automatic bit model_valid(input int startW);
    if (startW < S_START_MIN || startW > S_START_MAX) return 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (bitW[i] < S_BIT_MIN || bitW[i] > S_BIT_MAX) return 1'b0;
      if (spaceW[i] >= S_GAP) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_frame(input int startW, input bit doneSameCycle);
    if (!model_valid(startW)) begin
      expErr++;
    end else if (!mBusy || doneSameCycle) begin
      mCmd  = model_value();
      mBusy = 1'b1;
      expReady++;
    end
  endtask

  task automatic pulse_done();
    cmdIf.move_done = 1'b1;
    @(negedge clock);
    cmdIf.move_done = 1'b0;
    mBusy = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    irIn = 1'b1;
    cmdIf.move_done = 1'b0;
    repeat (3) @(negedge clock);
    checks++; if (cmdIf.command !== 12'h000) begin errors++; $display("[TB] FAIL reset_command: got %h expected 000", cmdIf.command); end
    checks++; if (cmdIf.command_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 0", cmdIf.command_ready); end
    checks++; if (cmdIf.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", cmdIf.busy); end
    checks++; if (frameError !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_error: got %b expected 0", frameError); end
    checks++; if (stateOut !== ST_IDLE) begin errors++; $display("[TB] FAIL reset_state: got %0d expected %0d", stateOut, ST_IDLE); end
    reset = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_single_frame();
    int lat = 0;
    fill_fixed(12'hA85);
    model_frame(60, 1'b0);
    send_raw(60, 12);
    irIn = 1'b1;
    while (cmdIf.command_ready !== 1'b1 && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    checks++; if (lat !== 4) begin errors++; $display("[TB] FAIL ready_latency: got %0d cycles expected 4", lat); end
    hold(1'b1, 8);
    checks++; if (readyCount !== expReady) begin errors++; $display("[TB] FAIL single_ready_count: got %0d expected %0d", readyCount, expReady); end
    checks++; if (readyCmd !== 12'hA85) begin errors++; $display("[TB] FAIL single_cmd_at_ready: got %h expected a85", readyCmd); end
    checks++; if (cmdIf.command !== mCmd) begin errors++; $display("[TB] FAIL single_cmd_held: got %h expected %h", cmdIf.command, mCmd); end
    checks++; if (cmdIf.command[11:7] !== 5'd21) begin errors++; $display("[TB] FAIL single_angle: got %0d expected 21", cmdIf.command[11:7]); end
    checks++; if (cmdIf.command[6:0] !== 7'd5) begin errors++; $display("[TB] FAIL single_distance: got %0d expected 5", cmdIf.command[6:0]); end
    checks++; if (cmdIf.busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy: got %b expected 1", cmdIf.busy); end
  endtask

  task automatic test_busy_drop();
    fill_fixed(12'h081);
    model_frame(60, 1'b0);
    send_raw(60, 12);
    hold(1'b1, 8);
    checks++; if (readyCount !== expReady) begin errors++; $display("[TB] FAIL drop_ready_count: got %0d expected %0d", readyCount, expReady); end
    checks++; if (cmdIf.command !== 12'hA85) begin errors++; $display("[TB] FAIL drop_cmd_kept: got %h expected a85", cmdIf.command); end
    checks++; if (cmdIf.busy !== 1'b1) begin errors++; $display("[TB] FAIL drop_busy: got %b expected 1", cmdIf.busy); end
    pulse_done();
    checks++; if (cmdIf.busy !== 1'b0) begin errors++; $display("[TB] FAIL done_clears_busy: got %b expected 0", cmdIf.busy); end
    model_frame(60, 1'b0);
    send_raw(60, 12);
    hold(1'b1, 8);
    checks++; if (readyCount !== expReady) begin errors++; $display("[TB] FAIL resend_ready_count: got %0d expected %0d", readyCount, expReady); end
    checks++; if (cmdIf.command !== 12'h081) begin errors++; $display("[TB] FAIL resend_cmd: got %h expected 081", cmdIf.command); end
    checks++; if (cmdIf.busy !== 1'b1) begin errors++; $display("[TB] FAIL resend_busy: got %b expected 1", cmdIf.busy); end
  endtask

  task automatic test_bad_start();
    hold(1'b0, 40);
    hold(1'b1, 10);
    expErr++;
    checks++; if (errCount !== expErr) begin errors++; $display("[TB] FAIL bad_start_error_pulse: got %0d expected %0d", errCount, expErr); end
    checks++; if (stateOut !== ST_ERROR) begin errors++; $display("[TB] FAIL bad_start_in_error: got %0d expected %0d", stateOut, ST_ERROR); end
    hold(1'b1, 10);
    checks++; if (stateOut !== ST_ERROR) begin errors++; $display("[TB] FAIL bad_start_waits_gap: got %0d expected %0d", stateOut, ST_ERROR); end
    hold(1'b1, 12);
    checks++; if (stateOut !== ST_IDLE) begin errors++; $display("[TB] FAIL bad_start_back_idle: got %0d expected %0d", stateOut, ST_IDLE); end
    checks++; if (readyCount !== expReady) begin errors++; $display("[TB] FAIL bad_start_no_ready: got %0d expected %0d", readyCount, expReady); end
  endtask

  task automatic test_gap_timeout();
    pulse_done();
    fill_fixed(12'h3C6);
    send_raw(60, 6);
    hold(1'b1, 30);
    expErr++;
    fill_fixed(12'h123);
    model_frame(60, 1'b0);
    send_raw(60, 12);
    hold(1'b1, 8);
    checks++; if (errCount !== expErr) begin errors++; $display("[TB] FAIL gap_error_pulse: got %0d expected %0d", errCount, expErr); end
    checks++; if (readyCount !== expReady) begin errors++; $display("[TB] FAIL gap_next_ready: got %0d expected %0d", readyCount, expReady); end
    checks++; if (cmdIf.command !== 12'h123) begin errors++; $display("[TB] FAIL gap_next_cmd: got %h expected 123", cmdIf.command); end
  endtask

  task automatic test_done_same_cycle();
    int startW = int'($urandom_range(S_START_MIN, S_START_MAX));
    fill_random();
    model_frame(startW, 1'b1);
    fork
      begin
        send_raw(startW, 12);
        hold(1'b1, 8);
      end
      begin
        int n = 0;
        while (stateOut !== ST_DONE && n < 3000) begin
          @(negedge clock);
          n++;
        end
        checks++; if (n >= 3000) begin errors++; $display("[TB] FAIL done_state_seen: got timeout expected state %0d", ST_DONE); end
        cmdIf.move_done = 1'b1;
        @(negedge clock);
        cmdIf.move_done = 1'b0;
      end
    join
    checks++; if (readyCount !== expReady) begin errors++; $display("[TB] FAIL samecycle_ready: got %0d expected %0d", readyCount, expReady); end
    checks++; if (cmdIf.command !== mCmd) begin errors++; $display("[TB] FAIL samecycle_cmd: got %h expected %h", cmdIf.command, mCmd); end
    checks++; if (cmdIf.busy !== 1'b1) begin errors++; $display("[TB] FAIL samecycle_busy: got %b expected 1", cmdIf.busy); end
  endtask

  task automatic test_reset_mid_frame();
    int startW;
    fill_random();
    send_raw(60, 7);
    hold(1'b1, spaceW[7]);
    hold(1'b0, 10);
    reset = 1'b1;
    irIn = 1'b1;
    repeat (2) @(negedge clock);
    mCmd = '0;
    mBusy = 1'b0;
    checks++; if (cmdIf.command !== 12'h000) begin errors++; $display("[TB] FAIL midreset_cmd: got %h expected 000", cmdIf.command); end
    checks++; if (cmdIf.busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy: got %b expected 0", cmdIf.busy); end
    checks++; if (stateOut !== ST_IDLE) begin errors++; $display("[TB] FAIL midreset_state: got %0d expected %0d", stateOut, ST_IDLE); end
    reset = 1'b0;
    hold(1'b1, 10);
    startW = int'($urandom_range(S_START_MIN, S_START_MAX));
    fill_random();
    model_frame(startW, 1'b0);
    send_raw(startW, 12);
    hold(1'b1, 8);
    checks++; if (readyCount !== expReady) begin errors++; $display("[TB] FAIL midreset_next_ready: got %0d expected %0d", readyCount, expReady); end
    checks++; if (cmdIf.command !== mCmd) begin errors++; $display("[TB] FAIL midreset_next_cmd: got %h expected %h", cmdIf.command, mCmd); end
  endtask

  task automatic test_back_to_back();
    pulse_done();
    fork
      begin
        fill_random();
        model_frame(60, 1'b0);
        send_raw(60, 12);
        hold(1'b1, 1);
        mBusy = 1'b0;
        fill_random();
        model_frame(55, 1'b0);
        send_raw(55, 12);
        hold(1'b1, 8);
      end
      begin
        int n = 0;
        while (cmdIf.command_ready !== 1'b1 && n < 3000) begin
          @(negedge clock);
          n++;
        end
        checks++; if (n >= 3000) begin errors++; $display("[TB] FAIL b2b_first_ready: got timeout expected pulse"); end
        cmdIf.move_done = 1'b1;
        @(negedge clock);
        cmdIf.move_done = 1'b0;
      end
    join
    checks++; if (readyCount !== expReady) begin errors++; $display("[TB] FAIL b2b_ready_count: got %0d expected %0d", readyCount, expReady); end
    checks++; if (cmdIf.command !== mCmd) begin errors++; $display("[TB] FAIL b2b_cmd: got %h expected %h", cmdIf.command, mCmd); end
    checks++; if (cmdIf.busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_busy: got %b expected 1", cmdIf.busy); end
  endtask

  task automatic test_random_frames();
    for (int iter = 0; iter < 8; iter++) begin
      int startW = int'($urandom_range(S_START_MIN, S_START_MAX));
      int kind   = int'($urandom_range(0, 5));
      if ($urandom_range(0, 1) == 1) pulse_done();
      fill_random();
      case (kind)
        0: startW = int'($urandom_range(30, 45));
        1: bitW[$urandom_range(0, 11)] = int'($urandom_range(2, 8));
        2: bitW[$urandom_range(0, 11)] = int'($urandom_range(40, 60));
        3: startW = int'($urandom_range(74, 90));
        default: ;
      endcase
      model_frame(startW, 1'b0);
      send_raw(startW, 12);
      hold(1'b1, 40);
      checks++; if (readyCount !== expReady) begin errors++; $display("[TB] FAIL rand%0d_ready: got %0d expected %0d", iter, readyCount, expReady); end
      checks++; if (errCount !== expErr) begin errors++; $display("[TB] FAIL rand%0d_errors: got %0d expected %0d", iter, errCount, expErr); end
      checks++; if (cmdIf.command !== mCmd) begin errors++; $display("[TB] FAIL rand%0d_cmd: got %h expected %h", iter, cmdIf.command, mCmd); end
      checks++; if (cmdIf.busy !== mBusy) begin errors++; $display("[TB] FAIL rand%0d_busy: got %b expected %b", iter, cmdIf.busy, mBusy); end
      checks++; if (stateOut !== ST_IDLE) begin errors++; $display("[TB] FAIL rand%0d_state: got %0d expected %0d", iter, stateOut, ST_IDLE); end
    end
  endtask

  initial begin
    cmdIf.move_done = 1'b0;
    test_reset();
    test_single_frame();
    test_busy_drop();
    test_bad_start();
    test_gap_timeout();
    test_done_same_cycle();
    test_reset_mid_frame();
    test_back_to_back();
    test_random_frames();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
